// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery exponentiation accumulator.
//   state_e  : controller states
//   words_f  : number of words in an operand
//   idx_w_f  : index width for a buffer of a given depth (at least 1 bit)
//   bit_w_f  : width of an exponent-bit counter that can hold EXP_BITS itself
package mont_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_INIT,
        ISSUE,
        WAIT_RESULT,
        OUTPUT
    } state_e;

    function automatic int words_f(input int bits_in_num, input int register_size);
        return bits_in_num / register_size;
    endfunction

    function automatic int idx_w_f(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int bit_w_f(input int exp_bits);
        return $clog2(exp_bits + 1);
    endfunction

endpackage

// File: rtl/word_buffer_2r1w.sv
// Small word buffer: one synchronous write port and NRD asynchronous read
// ports, suited to distributed RAM or flops. Contents are not reset.
//   clk_in    : clock
//   we_in     : write enable
//   waddr_in  : write address
//   wdata_in  : write data
//   raddr_in  : one read address per read port
//   rdata_out : one read data word per read port (combinational)
module word_buffer_2r1w #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int NRD    = 2,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk_in,
    input  logic                       we_in,
    input  logic [AW-1:0]              waddr_in,
    input  logic [DATA_W-1:0]          wdata_in,
    input  logic [NRD-1:0][AW-1:0]     raddr_in,
    output logic [NRD-1:0][DATA_W-1:0] rdata_out
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we_in) begin
            mem_q[waddr_in] <= wdata_in;
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rdata_out[i] = mem_q[raddr_in[i]];
        end
    end

endmodule

// File: rtl/mont_exp_accumulator.sv
// Square-and-multiply controller for Montgomery exponentiation. Holds the
// running product (acc) and R mod N (rmodn) as word buffers, consumes groups
// of squared-base words tagged with an exponent bit, issues word-pair
// operands to an external multiply/reduce pipeline and writes the reduced
// words back into acc. The final acc is streamed out with backpressure.
//   clk_in, rst_in        : clock, synchronous active-high reset
//   start_in, exp_len_in  : job start (IDLE only) and exponent length
//   init_*                : R mod N words, LS first (ready only in LOAD_INIT)
//   base_*                : squared-base words + exponent bit (ready only in ISSUE)
//   mul_*                 : operand pair to the multiplier
//   red_*                 : reduced words returning, LS first
//   result_*              : final product words, last marks the top word
//   busy_out, done_out    : state != IDLE, one-cycle completion pulse
//   err_out               : sticky, reduced word seen outside WAIT_RESULT
module mont_exp_accumulator
    import mont_pkg::*;
#(
    parameter int REGISTER_SIZE  = 32,
    parameter int BITS_IN_NUM    = 4096,
    parameter int EXP_BITS       = 2048,
    parameter int SKIP_ZERO_BITS = 0
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           start_in,
    input  logic [bit_w_f(EXP_BITS)-1:0]   exp_len_in,
    input  logic [REGISTER_SIZE-1:0]       init_data_in,
    input  logic                           init_valid_in,
    output logic                           init_ready_out,
    input  logic [REGISTER_SIZE-1:0]       base_data_in,
    input  logic                           base_bit_in,
    input  logic                           base_valid_in,
    output logic                           base_ready_out,
    output logic [REGISTER_SIZE-1:0]       mul_a_out,
    output logic [REGISTER_SIZE-1:0]       mul_b_out,
    output logic                           mul_valid_out,
    input  logic [REGISTER_SIZE-1:0]       red_data_in,
    input  logic                           red_valid_in,
    output logic [REGISTER_SIZE-1:0]       result_data_out,
    output logic                           result_valid_out,
    input  logic                           result_ready_in,
    output logic                           result_last_out,
    output logic                           busy_out,
    output logic                           done_out,
    output logic                           err_out
);

    localparam int WORDS = words_f(BITS_IN_NUM, REGISTER_SIZE);
    localparam int IDX_W = idx_w_f(WORDS);
    localparam int BIT_W = bit_w_f(EXP_BITS);
    localparam bit SKIP  = (SKIP_ZERO_BITS != 0);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
    logic [BIT_W-1:0]   exp_len_q, exp_len_d;
    logic               bit_q, bit_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               vld_p0, vld_p1;

    logic [REGISTER_SIZE-1:0] mul_a_p1, mul_b_p1;

    logic [IDX_W-1:0]   word_idx_inc;
    logic [BIT_W-1:0]   bit_idx_inc;
    logic               last_word;
    logic               eff_bit;
    logic               skip_word;
    logic               init_hs, base_hs, red_hs;

    logic                          acc_we;
    logic [REGISTER_SIZE-1:0]      acc_wdata;
    logic [1:0][REGISTER_SIZE-1:0] acc_rd;
    logic [REGISTER_SIZE-1:0]      rmodn_rd;

    assign word_idx_inc = word_idx_q + IDX_W'(1);
    assign bit_idx_inc  = bit_idx_q + BIT_W'(1);
    assign last_word    = (word_idx_q == IDX_W'(WORDS - 1));

    // The exponent bit is only meaningful on word 0; later words of the
    // group reuse the value captured there.
    assign eff_bit   = (word_idx_q == '0) ? base_bit_in : bit_q;
    assign skip_word = SKIP && !eff_bit;

    assign init_hs = (state_q == LOAD_INIT)   && init_valid_in;
    assign base_hs = (state_q == ISSUE)       && base_valid_in;
    assign red_hs  = (state_q == WAIT_RESULT) && red_valid_in;

    assign acc_we    = init_hs || red_hs;
    assign acc_wdata = init_hs ? init_data_in : red_data_in;

    // Port 0 feeds operand issue, port 1 feeds result output.
    word_buffer_2r1w #(
        .DATA_W (REGISTER_SIZE),
        .DEPTH  (WORDS),
        .NRD    (2)
    ) u_acc (
        .clk_in    (clk_in),
        .we_in     (acc_we),
        .waddr_in  (word_idx_q),
        .wdata_in  (acc_wdata),
        .raddr_in  ({word_idx_q, word_idx_q}),
        .rdata_out (acc_rd)
    );

    word_buffer_2r1w #(
        .DATA_W (REGISTER_SIZE),
        .DEPTH  (WORDS),
        .NRD    (1)
    ) u_rmodn (
        .clk_in    (clk_in),
        .we_in     (init_hs),
        .waddr_in  (word_idx_q),
        .wdata_in  (init_data_in),
        .raddr_in  (word_idx_q),
        .rdata_out (rmodn_rd)
    );

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        bit_idx_d  = bit_idx_q;
        exp_len_d  = exp_len_q;
        bit_d      = bit_q;
        err_d      = err_q;
        done_d     = 1'b0;
        vld_p0     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d    = LOAD_INIT;
                    exp_len_d  = exp_len_in;
                    err_d      = 1'b0;
                    word_idx_d = '0;
                    bit_idx_d  = '0;
                end
            end
            LOAD_INIT: begin
                if (init_valid_in) begin
                    word_idx_d = word_idx_inc;
                    if (last_word) begin
                        state_d = (exp_len_q == '0) ? OUTPUT : ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (base_valid_in) begin
                    bit_d      = eff_bit;
                    vld_p0     = !skip_word;
                    word_idx_d = word_idx_inc;
                    if (last_word) begin
                        // A skipped group has nothing in flight, so the bit
                        // is retired here instead of in WAIT_RESULT.
                        if (skip_word) begin
                            bit_idx_d = bit_idx_inc;
                            state_d   = (bit_idx_inc == exp_len_q) ? OUTPUT : ISSUE;
                        end else begin
                            state_d   = WAIT_RESULT;
                        end
                    end
                end
            end
            WAIT_RESULT: begin
                if (red_valid_in) begin
                    word_idx_d = word_idx_inc;
                    if (last_word) begin
                        bit_idx_d = bit_idx_inc;
                        state_d   = (bit_idx_inc == exp_len_q) ? OUTPUT : ISSUE;
                    end
                end
            end
            OUTPUT: begin
                if (result_ready_in) begin
                    word_idx_d = word_idx_inc;
                    if (last_word) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (red_valid_in && (state_q != WAIT_RESULT)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            bit_idx_q  <= '0;
            exp_len_q  <= '0;
            bit_q      <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            bit_idx_q  <= bit_idx_d;
            exp_len_q  <= exp_len_d;
            bit_q      <= bit_d;
            err_q      <= err_d;
            done_q     <= done_d;
            vld_p1     <= vld_p0;
        end
    end

    // Stage p0 -> p1: operand pair registered on the base handshake.
    always_ff @(posedge clk_in) begin
        if (base_hs) begin
            mul_a_p1 <= acc_rd[0];
            mul_b_p1 <= eff_bit ? base_data_in : rmodn_rd;
        end
    end

    // Data registers carry no reset, so data outputs are gated by their
    // valids to read as zero whenever nothing is being presented.
    assign mul_valid_out    = vld_p1;
    assign mul_a_out        = vld_p1 ? mul_a_p1 : '0;
    assign mul_b_out        = vld_p1 ? mul_b_p1 : '0;

    assign result_valid_out = (state_q == OUTPUT);
    assign result_data_out  = result_valid_out ? acc_rd[1] : '0;
    assign result_last_out  = result_valid_out && last_word;

    assign init_ready_out   = (state_q == LOAD_INIT);
    assign base_ready_out   = (state_q == ISSUE);
    assign busy_out         = (state_q != IDLE);
    assign done_out         = done_q;
    assign err_out          = err_q;

endmodule

// File: tb/tb_mont_exp_accumulator.sv
// Bench for mont_exp_accumulator: two instances (zero-bit skipping off and
// on) driven by directed jobs with random data, checked against a
// whole-number reference model of square-and-multiply with an XOR reducer.
module tb_mont_exp_accumulator;

    localparam int RS = 8;
    localparam int BN = 32;
    localparam int EB = 8;
    localparam int W  = BN / RS;
    localparam int LW = $clog2(EB + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start        [2];
    logic [LW-1:0] exp_len      [2];
    logic [RS-1:0] init_data    [2];
    logic          init_valid   [2];
    logic          init_ready   [2];
    logic [RS-1:0] base_data    [2];
    logic          base_bit     [2];
    logic          base_valid   [2];
    logic          base_ready   [2];
    logic [RS-1:0] mul_a        [2];
    logic [RS-1:0] mul_b        [2];
    logic          mul_valid    [2];
    logic [RS-1:0] red_data     [2];
    logic          red_valid    [2];
    logic [RS-1:0] result_data  [2];
    logic          result_valid [2];
    logic          result_ready [2];
    logic          result_last  [2];
    logic          busy         [2];
    logic          done         [2];
    logic          err          [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mont_exp_accumulator #(
            .REGISTER_SIZE  (RS),
            .BITS_IN_NUM    (BN),
            .EXP_BITS       (EB),
            .SKIP_ZERO_BITS (g)
        ) dut (
            .clk_in           (clk),
            .rst_in           (rst),
            .start_in         (start[g]),
            .exp_len_in       (exp_len[g]),
            .init_data_in     (init_data[g]),
            .init_valid_in    (init_valid[g]),
            .init_ready_out   (init_ready[g]),
            .base_data_in     (base_data[g]),
            .base_bit_in      (base_bit[g]),
            .base_valid_in    (base_valid[g]),
            .base_ready_out   (base_ready[g]),
            .mul_a_out        (mul_a[g]),
            .mul_b_out        (mul_b[g]),
            .mul_valid_out    (mul_valid[g]),
            .red_data_in      (red_data[g]),
            .red_valid_in     (red_valid[g]),
            .result_data_out  (result_data[g]),
            .result_valid_out (result_valid[g]),
            .result_ready_in  (result_ready[g]),
            .result_last_out  (result_last[g]),
            .busy_out         (busy[g]),
            .done_out         (done[g]),
            .err_out          (err[g])
        );
    end

    int vectors = 0;
    int miscompares = 0;

    // Observed operand beats and the external pipeline's pending results.
    logic [RS-1:0] q_a  [2][$];
    logic [RS-1:0] q_b  [2][$];
    logic [RS-1:0] pend [2][$];
    bit sending  [2];
    bit inj_seen [2];
    bit hold     [2];
    bit inj_tog  [2];

    // Job description shared by the stimulus and the reference model.
    int          j_len;
    logic [31:0] j_rmodn;
    logic [31:0] j_base [8];
    logic [7:0]  j_bits;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] outs(input int d);
        return {init_ready[d], base_ready[d], mul_a[d], mul_b[d], mul_valid[d],
                result_data[d], result_valid[d], result_last[d], busy[d], done[d], err[d]};
    endfunction

    // External multiply + reduce pipeline: returns a^b per word, in order,
    // once a whole group has been issued, with random gaps.
    initial begin
        for (int d = 0; d < 2; d++) begin
            red_valid[d] = 1'b0;
            red_data[d]  = '0;
            sending[d]   = 1'b0;
            inj_seen[d]  = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                red_valid[d] = 1'b0;
                if (rst) begin
                    pend[d].delete();
                    sending[d] = 1'b0;
                end else begin
                    if (mul_valid[d]) begin
                        q_a[d].push_back(mul_a[d]);
                        q_b[d].push_back(mul_b[d]);
                        pend[d].push_back(mul_a[d] ^ mul_b[d]);
                    end
                    if (pend[d].size() >= W) sending[d] = 1'b1;
                    if (inj_tog[d] != inj_seen[d]) begin
                        inj_seen[d]  = inj_tog[d];
                        red_valid[d] = 1'b1;
                        red_data[d]  = 8'hEE;
                    end else if (sending[d] && !hold[d] && $urandom_range(0, 2) != 0) begin
                        red_valid[d] = 1'b1;
                        red_data[d]  = pend[d].pop_front();
                        if (pend[d].size() == 0) sending[d] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic rand_job(input int len, input logic [7:0] bits);
        j_len   = len;
        j_rmodn = $urandom;
        for (int i = 0; i < 8; i++) j_base[i] = $urandom;
        j_bits  = bits;
    endtask

    // Entered and left at 1 time unit after a rising edge with the valid
    // already driven; returns right after the handshake edge.
    task automatic wait_hs(input int d, input bit is_base);
        int n;
        n = 0;
        @(negedge clk);
        while (((is_base ? base_ready[d] : init_ready[d]) !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("handshake_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int d, input bit inject, input bit abort);
        logic [31:0]   acc;
        logic [31:0]   op;
        logic [RS-1:0] ea[$];
        logic [RS-1:0] eb[$];
        int off, k, cyc, stalls, ngroups, nobs;

        // Reference: acc starts at R mod N; each kept group folds in the
        // base (bit 1) or R mod N (bit 0) through the XOR reducer.
        acc = j_rmodn;
        for (int g = 0; g < j_len; g++) begin
            if (j_bits[g] || d == 0) begin
                op = j_bits[g] ? j_base[g] : j_rmodn;
                for (int w = 0; w < W; w++) begin
                    ea.push_back(acc[RS*w +: RS]);
                    eb.push_back(op[RS*w +: RS]);
                end
                acc = acc ^ op;
            end
        end
        off = q_a[d].size();
        if (abort) hold[d] = 1'b1;

        start[d]   = 1'b1;
        exp_len[d] = LW'(j_len);
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy[d], 1);
        check("err_clear_on_start", err[d], 0);
        @(posedge clk);
        #1;

        for (int w = 0; w < W; w++) begin
            init_valid[d] = 1'b1;
            init_data[d]  = j_rmodn[RS*w +: RS];
            wait_hs(d, 1'b0);
        end
        init_valid[d] = 1'b0;

        if (inject) begin
            @(negedge clk);
            inj_tog[d] = ~inj_tog[d];
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("err_set", err[d], 1);
            @(posedge clk);
            #1;
        end

        ngroups = abort ? 1 : j_len;
        for (int g = 0; g < ngroups; g++) begin
            for (int w = 0; w < W; w++) begin
                base_valid[d] = 1'b1;
                base_data[d]  = j_base[g][RS*w +: RS];
                base_bit[d]   = (w == 0) ? j_bits[g] : 1'($urandom);
                wait_hs(d, 1'b1);
                if ($urandom_range(0, 3) == 0) begin
                    base_valid[d] = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
        end
        base_valid[d] = 1'b0;

        if (abort) begin
            @(negedge clk);
            check("wait_base_ready", base_ready[d], 0);
            check("wait_busy", busy[d], 1);
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("abort_outputs_zero", outs(d), 0);
            @(posedge clk);
            #1;
            rst     = 1'b0;
            hold[d] = 1'b0;
            @(posedge clk);
            #1;
            return;
        end

        k = 0;
        cyc = 0;
        stalls = 0;
        while (k < W && cyc < 400) begin
            result_ready[d] = !(k == 1 && stalls < 3);
            @(negedge clk);
            if (!result_ready[d]) begin
                stalls++;
                check("stall_valid", result_valid[d], 1);
                check("stall_hold", result_data[d], acc[RS +: RS]);
            end else if (result_valid[d]) begin
                check("result_word", result_data[d], acc[RS*k +: RS]);
                check("result_last", result_last[d], (k == W - 1));
                k++;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        if (k < W) check("result_timeout", k, W);
        result_ready[d] = 1'b0;
        @(negedge clk);
        check("done_pulse", done[d], 1);
        check("idle_after_done", busy[d], 0);
        @(negedge clk);
        check("done_single", done[d], 0);
        check("err_sticky", err[d], inject);
        @(posedge clk);
        #1;

        nobs = q_a[d].size() - off;
        check("beat_count", nobs, ea.size());
        for (int i = 0; i < ea.size() && i < nobs; i++) begin
            check("beat_a", q_a[d][off+i], ea[i]);
            check("beat_b", q_b[d][off+i], eb[i]);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d]        = 1'b0;
            exp_len[d]      = '0;
            init_data[d]    = '0;
            init_valid[d]   = 1'b0;
            base_data[d]    = '0;
            base_bit[d]     = 1'b0;
            base_valid[d]   = 1'b0;
            result_ready[d] = 1'b0;
            hold[d]         = 1'b0;
            inj_tog[d]      = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_0", outs(0), 0);
        check("reset_outputs_1", outs(1), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // exp_len = 0: result is R mod N itself.
        j_len   = 0;
        j_rmodn = 32'h04030201;
        j_bits  = 8'h00;
        run_job(0, 1'b0, 1'b0);

        // Bits 1,0 on both variants with identical data.
        rand_job(2, 8'b0000_0001);
        run_job(0, 1'b0, 1'b0);
        run_job(1, 1'b0, 1'b0);

        // Stray reduced word during ISSUE, then a clean job.
        rand_job(6, 8'($urandom));
        run_job(0, 1'b1, 1'b0);
        rand_job(5, 8'($urandom));
        run_job(0, 1'b0, 1'b0);

        rand_job(8, 8'($urandom));
        run_job(1, 1'b0, 1'b0);

        // Reset while waiting for reduced words, then a full job.
        rand_job(2, 8'b0000_0011);
        run_job(0, 1'b0, 1'b1);
        rand_job(3, 8'($urandom));
        run_job(0, 1'b0, 1'b0);
        rand_job(4, 8'($urandom));
        run_job(1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mont_exp_accumulator.md
Name: mont_exp_accumulator

Overview:
Parametrised controller for Montgomery square-and-multiply exponentiation. It holds the running product and R mod N in local word buffers, and consumes a stream of squared-base words tagged with exponent bits. It issues word-pair operands to an external multiplier + montgomery_reduce pipeline and writes the reduced words back into the accumulator. It generalises the single-job accumulator with:
- runtime exponent length;
- streamed R mod N loading (no fixed init file);
- optional zero-bit skipping;
- explicit start/done and backpressured result output.

Parameters:
REGISTER_SIZE, 32, word width in bits
BITS_IN_NUM, 4096, operand width; WORDS = BITS_IN_NUM/REGISTER_SIZE (power of 2, ≥2)
EXP_BITS, 2048, maximum exponent length
SKIP_ZERO_BITS, 0, 1: zero exponent bits issue no multiply; 0: multiply by R mod N (constant time)

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
start_in  in  1  job start pulse; honoured only in IDLE
exp_len_in  in  $clog2(EXP_BITS+1)  exponent bits to consume; latched on start
init_data_in  in  REGISTER_SIZE  R mod N word, LS word first
init_valid_in  in  1  init word valid
init_ready_out  out  1  high only in LOAD_INIT
base_data_in  in  REGISTER_SIZE  squared-base word
base_bit_in  in  1  exponent bit; sampled on word 0 of each group
base_valid_in  in  1  base word valid
base_ready_out  out  1  high only in ISSUE
mul_a_out  out  REGISTER_SIZE  multiplier operand A (accumulator word)
mul_b_out  out  REGISTER_SIZE  multiplier operand B
mul_valid_out  out  1  operand pair valid
red_data_in  in  REGISTER_SIZE  reduced word returning, LS first
red_valid_in  in  1  reduced word valid
result_data_out  out  REGISTER_SIZE  final product word
result_valid_out  out  1  result word valid
result_ready_in  in  1  result backpressure
result_last_out  out  1  marks word WORDS-1
busy_out  out  1  state != IDLE
done_out  out  1  one-cycle pulse after last result word accepted
err_out  out  1  sticky: red_valid_in outside WAIT_RESULT; cleared by reset or start

Behaviour:
- Reset: state IDLE; all outputs 0; word_idx = 0, bit_idx = 0. Buffer contents are don't-care. Reset mid-job aborts with no further outputs.
- IDLE: on start_in, latch exp_len, clear err_out, go to LOAD_INIT.
- LOAD_INIT: each init handshake writes rmodn[word_idx] and acc[word_idx]. After word WORDS-1, word_idx wraps to 0.
  - exp_len = 0 → OUTPUT.
  - otherwise → ISSUE.
- ISSUE: latch bit on the word-0 handshake and hold it for the group.
  - Each base handshake drives, registered one cycle later: mul_a_out = acc[word_idx], mul_b_out = bit ? base word : rmodn[word_idx], mul_valid_out = 1.
  - With SKIP_ZERO_BITS=1 and bit 0: words are consumed, mul_valid_out stays 0, and acc is unchanged.
  - After word WORDS-1:
    - skipped group → bit_idx++, then OUTPUT if bit_idx == exp_len, else stay in ISSUE.
    - otherwise → WAIT_RESULT.
- WAIT_RESULT: base_ready_out = 0. Each red_valid_in writes acc[word_idx]; downstream latency is arbitrary.
  - After word WORDS-1: bit_idx++, then OUTPUT if bit_idx == exp_len, else ISSUE.
- OUTPUT: result_data_out = acc[word_idx], held stable while result_ready_in is low.
  - On the handshake of the last word: done_out pulses next cycle and state returns to IDLE.
- Widths: word_idx is $clog2(WORDS) and wraps naturally. bit_idx is $clog2(EXP_BITS+1). No arithmetic on data words.
- Ignored inputs: start_in while busy; base/init valids when the matching ready is low.
- Throughput: one operand pair per cycle while base_valid_in is held high.

Decomposition:
- Package mont_pkg: state enum (IDLE, LOAD_INIT, ISSUE, WAIT_RESULT, OUTPUT), WORDS and index-width localparam functions.
- Sub-module word_buffer_2r1w: acc storage with one write port, a read port for issue and a read port for output; distributed RAM or registers.
- rmodn is a separate single-port instance of the same sub-module.

Test Plan:
- REGISTER_SIZE=8, BITS_IN_NUM=32, exp_len=0, init words 01,02,03,04 → result 01,02,03,04 with last on word 3, then done pulse.
- exp_len=2, bits 1,0, SKIP_ZERO_BITS=0, pipeline model returning a^b per word → 8 mul_valid beats; second group's mul_b equals rmodn words.
- Same stimulus with SKIP_ZERO_BITS=1 → exactly 4 mul_valid beats; result reflects only bit 1.
- result_ready_in low for 3 cycles mid-output → data and valid held, no word lost or duplicated, done once.
- red_valid_in pulsed during ISSUE → err_out set and held until next start; acc unchanged.
- rst_in asserted in WAIT_RESULT → next cycle busy_out=0 and all outputs 0; a new job then completes correctly.
